reg_desloc_universal: RTL and testbench

Parametrised universal shift register that replaces the per-bit special flip-flop chain with one WIDTH-bit block.
- Keeps the 2-bit mode select: parallel load, single shift, OR-merge, hold.
- Adds direction control, rotate-versus-fill, and a multi-step "shift N positions" command.
- The multi-step command is run by an internal FSM with busy/done handshake.
- Sits between the register file and the serial/display datapath.

---
 rtl/reg_desloc_universal.sv | 159 +++++++++++++++
 tb/tb_reg_desloc_universal.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_desloc_universal.sv
// ---------------------------------------------------------------------------
// reg_desloc_universal
//
// Purpose:
//   WIDTH-bit universal shift register sitting between the register file and
//   the serial/display datapath.  In IDLE the 2-bit mode select performs a
//   parallel load, a single shift, an OR-merge or a hold every clock.  A
//   "shift N positions" command (start/amount) is executed by a small FSM
//   that shifts once per clock using the direction/rotate settings captured
//   when the command was accepted, then pulses done for one cycle.
//
// Ports:
//   clk        - system clock, all state changes on the rising edge
//   rst_n      - synchronous reset, active-low
//   ch         - IDLE mode: 00 load, 01 single shift, 10 OR-merge, 11 hold
//   dir        - 0 = shift right (toward bit 0), 1 = shift left
//   rot        - 1 = rotate (outgoing bit re-enters), 0 = fill with serial_in
//   serial_in  - fill bit for non-rotating shifts
//   load_val   - parallel load data (ch = 00)
//   or_val     - OR-merge operand (ch = 10)
//   start      - request a multi-step shift of `amount` positions
//   amount     - number of positions for a start command
//   q          - register contents
//   serial_out - bit currently leaving the register (combinational)
//   busy       - high while a multi-step shift is in progress
//   done       - one-cycle pulse when a start command completes
// ---------------------------------------------------------------------------
module reg_desloc_universal #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       ch,
    input  logic             dir,
    input  logic             rot,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] or_val,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFTING = 2'd1,
        ST_DONE     = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [AMT_W-1:0]   r_count;
    logic               r_dir;
    logic               r_rot;
    logic [WIDTH-1:0]   r_q;
    logic               w_effDir;

    // One-position shift; the fill bit is either the bit falling off the
    // far end (rotate) or the serial input.
    function automatic logic [WIDTH-1:0] shiftOnce(
        input logic [WIDTH-1:0] val,
        input logic             d,
        input logic             r,
        input logic             s
    );
        logic fillBit;
        if (d) begin
            fillBit   = r ? val[WIDTH-1] : s;
            shiftOnce = {val[WIDTH-2:0], fillBit};
        end else begin
            fillBit   = r ? val[0] : s;
            shiftOnce = {fillBit, val[WIDTH-1:1]};
        end
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic.  A zero-length command skips SHIFTING entirely;
    // the last shift happens on the edge where the counter reads 1.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_nextState = (amount != '0) ? ST_SHIFTING : ST_DONE;
                end
            end
            ST_SHIFTING: begin
                if (r_count == AMT_W'(1)) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Output decode.  serial_out follows the live dir in IDLE and the
    // captured dir while a command owns the register.
    always_comb begin
        busy       = (r_state == ST_SHIFTING);
        done       = (r_state == ST_DONE);
        w_effDir   = (r_state == ST_IDLE) ? dir : r_dir;
        serial_out = w_effDir ? r_q[WIDTH-1] : r_q[0];
    end

    // Datapath: register contents, command counter and captured settings.
    // start wins over ch in IDLE and leaves q untouched on the accept edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q     <= '0;
            r_count <= '0;
            r_dir   <= 1'b0;
            r_rot   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_dir   <= dir;
                        r_rot   <= rot;
                        r_count <= amount;
                    end else begin
                        case (ch)
                            2'b00:   r_q <= load_val;
                            2'b01:   r_q <= shiftOnce(r_q, dir, rot, serial_in);
                            2'b10:   r_q <= r_q | or_val;
                            default: r_q <= r_q;
                        endcase
                    end
                end
                ST_SHIFTING: begin
                    r_q     <= shiftOnce(r_q, r_dir, r_rot, serial_in);
                    r_count <= r_count - 1'b1;
                end
                default: begin
                    r_q <= r_q;
                end
            endcase
        end
    end

    assign q = r_q;

endmodule

// File: tb/tb_reg_desloc_universal.sv
// ---------------------------------------------------------------------------
// tb_reg_desloc_universal
//
// Purpose:
//   Self-checking bench for reg_desloc_universal (WIDTH=8, AMT_W=4).
//   Directed steps followed by randomized operations; expected register
//   contents come from a shift-by-N reference written with plain
//   arithmetic on whole words.
// ---------------------------------------------------------------------------
module tb_reg_desloc_universal;

    localparam int WIDTH = 8;
    localparam int AMT_W = 4;

    logic             clk;
    logic             rst_n;
    logic [1:0]       ch;
    logic             dir;
    logic             rot;
    logic             serial_in;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] or_val;
    logic             start;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] q;
    logic             serial_out;
    logic             busy;
    logic             done;

    int errors = 0;
    int checks = 0;
    logic [7:0] mq;

    reg_desloc_universal #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ch         (ch),
        .dir        (dir),
        .rot        (rot),
        .serial_in  (serial_in),
        .load_val   (load_val),
        .or_val     (or_val),
        .start      (start),
        .amount     (amount),
        .q          (q),
        .serial_out (serial_out),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the word after n shifts, computed in one go.
    function automatic logic [7:0] modelShift(input logic [7:0] v, input logic d,
                                              input logic r, input logic s, input int n);
        logic [7:0] ones;
        logic [7:0] res;
        int k;
        ones = 8'hFF;
        if (r) begin
            k = n % 8;
            if (d) res = (v << k) | (v >> (8 - k));
            else   res = (v >> k) | (v << (8 - k));
        end else if (n >= 8) begin
            res = s ? 8'hFF : 8'h00;
        end else if (d) begin
            res = (v << n) | (s ? ~(ones << n) : 8'h00);
        end else begin
            res = (v >> n) | (s ? ~(ones >> n) : 8'h00);
        end
        return res;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] c, input logic d, input logic r,
                                 input logic s, input logic [7:0] lv, input logic [7:0] ov);
        ch = c; dir = d; rot = r; serial_in = s; load_val = lv; or_val = ov;
        #1;
        case (c)
            2'b00: mq = lv;
            2'b01: begin
                checkOutput("idle_serial_out", serial_out, d ? mq[7] : mq[0]);
                mq = modelShift(mq, d, r, s, 1);
            end
            2'b10: mq = mq | ov;
            default: mq = mq;
        endcase
        step();
        checkOutput("idle_q", q, mq);
    endtask

    // Full multi-step command.  Inputs that must be ignored are scrambled
    // after acceptance; serial_in stays constant so the reference applies.
    task automatic runCommand(input int amt, input logic d, input logic r,
                              input logic s, input logic reStart);
        logic [7:0] expQ;
        int n;
        expQ = modelShift(mq, d, r, s, amt);
        start = 1'b1; amount = AMT_W'(amt); dir = d; rot = r; serial_in = s;
        ch = 2'b00; load_val = 8'h3E;
        step();
        checkOutput("accept_q", q, mq);
        start = reStart; dir = ~d; rot = ~r;
        #1;
        checkOutput("cmd_serial_out", serial_out, d ? mq[7] : mq[0]);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            step();
        end
        checkOutput("busy_cycles", n, amt);
        checkOutput("done_pulse", done, 1'b1);
        checkOutput("cmd_q", q, expQ);
        mq = expQ;
        step();
        start = 1'b0; ch = 2'b11;
        checkOutput("done_clear", done, 1'b0);
        checkOutput("busy_clear", busy, 1'b0);
        step();
        checkOutput("single_done", done, 1'b0);
        checkOutput("hold_q", q, mq);
    endtask

    initial begin
        rst_n = 1'b0; ch = 2'b00; dir = 1'b0; rot = 1'b0; serial_in = 1'b0;
        load_val = 8'hFF; or_val = 8'h00; start = 1'b0; amount = '0;
        mq = 8'h00;

        // Reset holds the register clear despite a pending load.
        step();
        step();
        checkOutput("rst_q", q, 8'h00);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        rst_n = 1'b1;
        step();
        mq = 8'hFF;
        checkOutput("post_rst_load", q, 8'hFF);

        // Single shifts.
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h00);
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        checkOutput("shift_right_fill", q, 8'hD2);
        applyStimulus(2'b01, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
        checkOutput("shift_left_rot", q, 8'hA5);

        // Multi-step rotate left by 3.
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 8'h81, 8'h00);
        runCommand(3, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("rot3_result", q, 8'h0C);

        // OR-merge then hold.
        applyStimulus(2'b10, 1'b0, 1'b0, 1'b0, 8'h00, 8'h30);
        checkOutput("or_merge", q, 8'h3C);
        for (int i = 0; i < 5; i++) applyStimulus(2'b11, 1'b1, 1'b0, 1'b1, 8'h00, 8'hFF);
        checkOutput("hold5", q, 8'h3C);

        // Edge commands.
        runCommand(0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00);
        runCommand(10, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("fill10_result", q, 8'h00);
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 8'h96, 8'h00);
        runCommand(5, 1'b0, 1'b1, 1'b0, 1'b1);
        runCommand(15, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a command.
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h00);
        start = 1'b1; amount = 4'd7; dir = 1'b0; rot = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        checkOutput("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        step();
        checkOutput("mid_rst_q", q, 8'h00);
        checkOutput("mid_rst_busy", busy, 1'b0);
        checkOutput("mid_rst_done", done, 1'b0);
        rst_n = 1'b1; ch = 2'b11;
        mq = 8'h00;
        for (int i = 0; i < 8; i++) begin
            step();
            checkOutput("no_late_done", done, 1'b0);
        end
        checkOutput("mid_rst_hold", q, 8'h00);

        // Randomized operations against the reference.
        for (int i = 0; i < 40; i++) begin
            int op;
            op = $urandom_range(0, 4);
            if (op == 4) begin
                runCommand($urandom_range(0, 15), 1'($urandom), 1'($urandom),
                           1'($urandom), 1'($urandom));
            end else begin
                applyStimulus(2'(op), 1'($urandom), 1'($urandom), 1'($urandom),
                              8'($urandom), 8'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
